// File: rtl/vector_sweep_bist_if.sv
// Handshake and data bundle between vector_sweep_bist and whoever drives it.
// Macro VECTOR_SWEEP_SIG_CHECK_EN adds the golden/pass signature-compare pair.
interface vector_sweep_bist_if #(
  parameter int K = 3,
  parameter int M = 1,
  parameter int S = 8
);
  logic         start;
  logic         abort;
  logic         gray;
  logic [K-1:0] vec;
  logic [M-1:0] resp;
  logic         busy;
  logic         done;
  logic [S-1:0] signature;
`ifdef VECTOR_SWEEP_SIG_CHECK_EN
  logic [S-1:0] golden;
  logic         pass;

  modport master (output start, abort, gray, resp, golden,
                  input  vec, busy, done, signature, pass);
  modport slave  (input  start, abort, gray, resp, golden,
                  output vec, busy, done, signature, pass);
`else
  modport master (output start, abort, gray, resp,
                  input  vec, busy, done, signature);
  modport slave  (input  start, abort, gray, resp,
                  output vec, busy, done, signature);
`endif
endinterface

// File: rtl/vector_sweep_bist.sv
// Exhaustive K-bit vector sweep (binary or Gray order) with an S-bit MISR over the responses.
// Macro VECTOR_SWEEP_SIG_CHECK_EN adds a compare of the final signature against bus.golden.
module vector_sweep_bist #(
  parameter int           K    = 3,
  parameter int           M    = 1,
  parameter int           S    = 8,
  parameter logic [S-1:0] POLY = 'h1D,
  parameter logic [S-1:0] SEED = '0
) (
  input  logic                clk,
  input  logic                reset,
  vector_sweep_bist_if.slave  bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   state;
  logic [K-1:0] cnt;
  logic         mode;
  logic [S-1:0] sig;
  logic [S-1:0] resp_ext;
  logic [S-1:0] misr_next;

  // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    resp_ext         = '0;
    resp_ext[M-1:0]  = bus.resp;
    misr_next        = {sig[S-2:0], 1'b0} ^ (sig[S-1] ? POLY : '0) ^ resp_ext;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mode  <= 1'b0;
      sig   <= SEED;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          // start outranks a simultaneous abort here; abort alone does nothing outside RUN.
          if (bus.start) begin
            state <= ST_RUN;
            cnt   <= '0;
            mode  <= bus.gray;
            sig   <= SEED;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else begin
            sig <= misr_next;
            // cnt parks on all-ones in DONE so vec keeps showing the last vector.
            if (cnt == '1) state <= ST_DONE;
            else           cnt   <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.vec       = mode ? (cnt ^ (cnt >> 1)) : cnt;
  assign bus.busy      = (state == ST_RUN);
  assign bus.done      = (state == ST_DONE);
  assign bus.signature = sig;

`ifdef VECTOR_SWEEP_SIG_CHECK_EN
  assign bus.pass = (state == ST_DONE) && (sig == bus.golden);
`endif
endmodule

// File: tb/tb_vector_sweep_bist.sv
// Bench for vector_sweep_bist with K=2, S=4, POLY=4'h3, SEED=0 and resp = vec[0] (or tied 0).
// Table-driven sweeps with a vector scoreboard, plus hand sequences for abort, reset and priority.
module tb_vector_sweep_bist;
  localparam int K = 2;
  localparam int M = 1;
  localparam int S = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  logic rzero = 1'b0;
  int   n_cmp  = 0;
  int   n_fail = 0;
  logic [K-1:0] exp_q[$];

  vector_sweep_bist_if #(.K(K), .M(M), .S(S)) bus ();

  vector_sweep_bist #(.K(K), .M(M), .S(S), .POLY(4'h3), .SEED(4'h0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign bus.resp = rzero ? 1'b0 : bus.vec[0];

  typedef struct {
    logic       g;
    logic       rz;
    logic       poke;
    logic [3:0] sig;
  } sweep_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Full sweep: push expected vectors at start, pop them while busy, then check DONE results.
  task automatic sweep(input sweep_t t);
    int cycles;
    logic [K-1:0] e;
    rzero = t.rz;
    @(negedge clk);
    bus.start = 1'b1;
    bus.gray  = t.g;
    for (int i = 0; i < (1 << K); i++) begin
      e = K'(i);
      exp_q.push_back(t.g ? (e ^ (e >> 1)) : e);
    end
    @(negedge clk);
    bus.start = 1'b0;
    check("done_low_after_start", bus.done, 1'b0);
    cycles = 0;
    while (bus.busy && cycles < 12) begin
      check("q_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) check("vec", bus.vec, exp_q.pop_front());
`ifdef VECTOR_SWEEP_SIG_CHECK_EN
      bus.golden = t.sig;
      check("pass_low_busy", bus.pass, 1'b0);
`endif
      cycles++;
      bus.start = (t.poke && cycles == 1);
      @(negedge clk);
    end
    bus.start = 1'b0;
    check("busy_cycles", cycles, 1 << K);
    check("q_drained", exp_q.size(), 0);
    check("done", bus.done, 1'b1);
    check("busy_after", bus.busy, 1'b0);
    check("signature", bus.signature, t.sig);
    check("vec_hold", bus.vec, t.g ? 2'b10 : 2'b11);
`ifdef VECTOR_SWEEP_SIG_CHECK_EN
    bus.golden = t.sig;
    #1 check("pass_match", bus.pass, 1'b1);
    bus.golden = ~t.sig;
    #1 check("pass_nomatch", bus.pass, 1'b0);
`endif
    exp_q.delete();
  endtask

  initial begin
    sweep_t tbl[4];
    tbl[0] = '{g: 1'b0, rz: 1'b0, poke: 1'b1, sig: 4'h5};
    tbl[1] = '{g: 1'b1, rz: 1'b0, poke: 1'b0, sig: 4'h6};
    tbl[2] = '{g: 1'b0, rz: 1'b1, poke: 1'b0, sig: 4'h0};
    tbl[3] = '{g: 1'b0, rz: 1'b1, poke: 1'b0, sig: 4'h0};

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.gray  = 1'b0;
`ifdef VECTOR_SWEEP_SIG_CHECK_EN
    bus.golden = 4'h5;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_vec", bus.vec, 2'b00);
    check("rst_sig", bus.signature, 4'h0);
`ifdef VECTOR_SWEEP_SIG_CHECK_EN
    check("rst_pass", bus.pass, 1'b0);
`endif
    reset = 1'b1;

    for (int i = 0; i < 4; i++) sweep(tbl[i]);

    // Abort on the third RUN cycle: partial signature 4'h1 must survive.
    rzero = 1'b0;
    @(negedge clk); bus.start = 1'b1; bus.gray = 1'b0;
    @(negedge clk); bus.start = 1'b0;
    check("ab_vec0", bus.vec, 2'd0);
    @(negedge clk);
    check("ab_vec1", bus.vec, 2'd1);
    @(negedge clk);
    check("ab_vec2", bus.vec, 2'd2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("ab_busy", bus.busy, 1'b0);
    check("ab_done", bus.done, 1'b0);
    check("ab_vec", bus.vec, 2'd0);
    check("ab_sig", bus.signature, 4'h1);

    // abort in IDLE does nothing.
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("idle_abort_busy", bus.busy, 1'b0);
    check("idle_abort_sig", bus.signature, 4'h1);

    // Reach DONE, then start and abort together: start wins.
    sweep(tbl[0]);
    bus.start = 1'b1; bus.abort = 1'b1; bus.gray = 1'b0;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    check("start_wins_busy", bus.busy, 1'b1);
    check("start_wins_done", bus.done, 1'b0);

    // Asynchronous reset mid-sweep, away from any clock edge.
    @(posedge clk); @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_busy", bus.busy, 1'b0);
    check("arst_done", bus.done, 1'b0);
    check("arst_vec", bus.vec, 2'd0);
    check("arst_sig", bus.signature, 4'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("no_resume_busy", bus.busy, 1'b0);
    check("no_resume_done", bus.done, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
